ext_mem_ctrl: RTL and testbench



---
 rtl/ext_mem_pkg.sv | 23 ++
 rtl/ext_mem_timer.sv | 40 ++++
 rtl/ext_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_ext_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and defaults for the external memory controller.
// Set EXT_MEM_TIMEOUT_EN to build the ack-timeout/abort path.
package ext_mem_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_REQ     = 3'd1;
  localparam state_t ST_RELEASE = 3'd2;
  localparam state_t ST_DONE    = 3'd3;
`ifdef EXT_MEM_TIMEOUT_EN
  localparam state_t ST_ABORT   = 3'd4;
`endif

  localparam int unsigned DEF_TIMEOUT_CYC = 16;
  localparam logic [31:0] DEF_ERR_DATA    = 32'h0000_0000;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ext_mem_timer.sv
// Ack wait counter: clears while clear_i is high, counts while en_i is high,
// flags expired_o once the count reaches TIMEOUT_CYC-1 (saturates there).
module ext_mem_timer
  import ext_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYC);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ext_mem_ctrl.sv
// CPU-to-external-memory bridge using a four-phase req/ack handshake; 3-cycle minimum access.
// Optional macro EXT_MEM_TIMEOUT_EN adds an ack timeout that aborts with cpu_err.
module ext_mem_ctrl
  import ext_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata
);

  state_t      state_q;
  state_t      state_d;
  logic        ext_we_q;
  logic [31:0] ext_addr_q;
  logic [31:0] ext_wdata_q;
  logic [31:0] cpu_rdata_q;
  logic        start;
  logic        in_req;
  logic        timed_out;

  assign start  = (state_q == ST_IDLE) && cpu_req && cs;
  assign in_req = (state_q == ST_REQ);

`ifdef EXT_MEM_TIMEOUT_EN
  logic tmr_expired;

  // Held clear outside REQ so every access starts its wait from zero.
  ext_mem_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (!in_req),
    .en_i     (in_req),
    .expired_o(tmr_expired)
  );

  assign timed_out = in_req && tmr_expired && !ext_ack;
  assign cpu_err   = (state_q == ST_ABORT);
`else
  assign timed_out = 1'b0;
  assign cpu_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        // A late ack wins over a timeout landing in the same cycle.
        if (ext_ack) begin
          state_d = ST_RELEASE;
        end else if (timed_out) begin
`ifdef EXT_MEM_TIMEOUT_EN
          state_d = ST_ABORT;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_RELEASE: begin
        if (!ext_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
`ifdef EXT_MEM_TIMEOUT_EN
      ST_ABORT: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Access attributes are captured once and frozen until the next IDLE->REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
    end else if (start) begin
      ext_we_q    <= cpu_we;
      ext_addr_q  <= cpu_addr;
      ext_wdata_q <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
    end else if (in_req && !ext_we_q) begin
      if (ext_ack) begin
        cpu_rdata_q <= ext_rdata;
      end else if (timed_out) begin
        cpu_rdata_q <= ERR_DATA;
      end
    end
  end

  assign ext_req   = in_req;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_stall = start || in_req || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Scoreboard bench for ext_mem_ctrl: directed accesses against a four-phase memory model.
module tb_ext_mem_ctrl;

  localparam int unsigned TO_CYC = 16;
  localparam logic [31:0] ERRD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ack;
  logic [31:0] ext_rdata;

  always #5 clk = ~clk;

  ext_mem_ctrl #(
    .TIMEOUT_CYC(TO_CYC),
    .ERR_DATA   (ERRD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_err  (cpu_err),
    .ext_req  (ext_req),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata),
    .ext_ack  (ext_ack),
    .ext_rdata(ext_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          req_cyc;
    int          stall_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          mem_delay = 0;
  logic [31:0] mem_data  = '0;
  bit          hold_ack  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: ack after mem_delay cycles of ext_req (-1 = never), drop when ext_req drops.
  initial begin : mem_model
    int cnt;
    cnt       = 0;
    ext_ack   = 1'b0;
    ext_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt     = 0;
        ext_ack = 1'b0;
      end else if (ext_req) begin
        cnt++;
        if (mem_delay >= 0 && cnt > mem_delay) begin
          ext_ack   = 1'b1;
          ext_rdata = mem_data;
        end
      end else begin
        cnt = 0;
        if (!hold_ack) ext_ack = 1'b0;
      end
    end
  end

  // Monitor: counts req/stall cycles, pops and compares when an access finishes.
  initial begin : monitor
    int   req_cnt;
    int   stall_cnt;
    bit   prev_stall;
    bit   hold_bad;
    exp_t e;
    req_cnt = 0; stall_cnt = 0; prev_stall = 0; hold_bad = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_cnt = 0; stall_cnt = 0; prev_stall = 0; hold_bad = 0;
      end else begin
        if (ext_req) begin
          req_cnt++;
          if (sb_q.size() > 0) begin
            if (ext_addr !== sb_q[0].addr || ext_we !== sb_q[0].we ||
                (sb_q[0].we && ext_wdata !== sb_q[0].wdata)) hold_bad = 1;
          end
        end
        if (cpu_stall) stall_cnt++;
        if (cpu_err || (prev_stall && !cpu_stall)) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_completion: got err=%b with empty scoreboard (t=%0t)", cpu_err, $time);
          end else begin
            e = sb_q.pop_front();
            chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
            chk("ext_req_cycles", req_cnt, e.req_cyc);
            chk("stall_cycles", stall_cnt, e.stall_cyc);
            chk("ext_addr", ext_addr, e.addr);
            chk("ext_we", {31'd0, ext_we}, {31'd0, e.we});
            chk("ext_fields_stable", {31'd0, hold_bad}, 32'd0);
            if (e.we) chk("ext_wdata", ext_wdata, e.wdata);
            else      chk("cpu_rdata", cpu_rdata, e.rdata);
          end
          req_cnt = 0; stall_cnt = 0; hold_bad = 0;
        end
        prev_stall = cpu_stall;
      end
    end
  end

  // Called one step after a rising edge; returns one step after the edge that ends DONE/ABORT.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input bit exp_err,
                           input bit scramble);
    exp_t e;
    int   cyc;
    e.we        = we;
    e.addr      = addr;
    e.wdata     = wdata;
    e.rdata     = exp_err ? ERRD : rdata;
    e.err       = exp_err;
    e.req_cyc   = exp_err ? int'(TO_CYC) : delay + 1;
    e.stall_cyc = exp_err ? e.req_cyc + 1 : e.req_cyc + 2;
    sb_q.push_back(e);
    mem_delay = delay;
    mem_data  = rdata;
    cpu_req   = 1'b1;
    cs        = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      cyc++;
      if (cyc > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL access_wait: got no completion after %0d cycles, required completion", cyc);
        break;
      end
      @(posedge clk); #1;
      if (scramble && cyc == 2) begin
        cs        = 1'b0;
        cpu_we    = ~we;
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cs      = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; cs = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    #3;
    chk("rst_ext_req", {31'd0, ext_req}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    chk("rst_ext_addr", ext_addr, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Immediate-ack read, then a slow write whose CPU-side inputs change mid-access.
    do_access(1'b0, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    do_access(1'b1, 32'h0000_3004, 32'h1234_5678, 32'h0, 5, 1'b0, 1'b1);

    // Internal-memory select never reaches the external bus.
    cpu_req = 1'b1; cs = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0000_1800;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cs0_ext_req", {31'd0, ext_req}, 32'd0);
      chk("cs0_stall", {31'd0, cpu_stall}, 32'd0);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Back-to-back accesses, each restarting in the IDLE cycle after DONE.
    do_access(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_C0DE, 2, 1'b0, 1'b0);
    do_access(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 32'h0, 1, 1'b0, 1'b0);
    do_access(1'b0, 32'h0000_0048, 32'h0, 32'h1122_3344, 0, 1'b0, 1'b0);

`ifdef EXT_MEM_TIMEOUT_EN
    do_access(1'b0, 32'h0000_5000, 32'h0, 32'h0, -1, 1'b1, 1'b0);
    do_access(1'b0, 32'h0000_5004, 32'h0, 32'h600D_F00D, int'(TO_CYC) - 1, 1'b0, 1'b0);
`endif

    // Reset while parked in RELEASE (memory keeps ack high).
    hold_ack = 1'b1; mem_delay = 0; mem_data = 32'h0;
    cpu_req = 1'b1; cs = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h0000_6000; cpu_wdata = 32'h5555_AAAA;
    repeat (3) @(negedge clk);
    chk("release_ext_req", {31'd0, ext_req}, 32'd0);
    chk("release_stall", {31'd0, cpu_stall}, 32'd1);
    chk("release_ext_we", {31'd0, ext_we}, 32'd1);
    #2;
    cpu_req = 1'b0; cs = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_ext_req", {31'd0, ext_req}, 32'd0);
    chk("arst_ext_we", {31'd0, ext_we}, 32'd0);
    chk("arst_ext_addr", ext_addr, 32'd0);
    chk("arst_ext_wdata", ext_wdata, 32'd0);
    chk("arst_cpu_rdata", cpu_rdata, 32'd0);
    chk("arst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("arst_err", {31'd0, cpu_err}, 32'd0);
    hold_ack = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 1, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
